// File: rtl/control_pipe_if.sv
// Control-pipe bus: decode-stage control word and register fields in,
// staged control fields, WB destination and load-use stall out.
interface control_pipe_if #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned REG_W  = 5
);
  logic [CTRL_W-1:0] inControl;
  logic              inValid;
  logic [REG_W-1:0]  inRs;
  logic [REG_W-1:0]  inRt;
  logic [REG_W-1:0]  inRd;
  logic              inFlush;
  logic [3:0]        outExCtrl;
  logic [2:0]        outMemCtrl;
  logic [1:0]        outWbCtrl;
  logic [REG_W-1:0]  outWriteReg;
  logic              outStall;

  modport master (
    output inControl, inValid, inRs, inRt, inRd, inFlush,
    input  outExCtrl, outMemCtrl, outWbCtrl, outWriteReg, outStall
  );

  modport slave (
    input  inControl, inValid, inRs, inRt, inRd, inFlush,
    output outExCtrl, outMemCtrl, outWbCtrl, outWriteReg, outStall
  );
endinterface

// File: rtl/control_pipe.sv
// Pipelined control path: ID/EX, EX/MEM and MEM/WB control registers with
// load-use stall detection, branch flush and $0 write suppression.
// Control word layout: [8:5] EX {RegDst, ALUOp[1:0], ALUSrc},
// [4:2] MEM {Branch, MemRead, MemWrite}, [1:0] WB {RegWrite, MemtoReg}.
module control_pipe #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned REG_W  = 5
) (
  input logic             clk,
  input logic             rst,
  control_pipe_if.slave   bus
);

  localparam int unsigned RegDstBit   = 8;
  localparam int unsigned MemReadBit  = 3;
  localparam int unsigned RegWriteBit = 1;

  logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
  logic [REG_W-1:0]  idex_rs_q, idex_rs_d;
  logic [REG_W-1:0]  idex_rt_q, idex_rt_d;
  logic [REG_W-1:0]  idex_rd_q, idex_rd_d;
  logic [4:0]        exmem_ctrl_q, exmem_ctrl_d;
  logic [REG_W-1:0]  exmem_dst_q, exmem_dst_d;
  logic [1:0]        memwb_ctrl_q, memwb_ctrl_d;
  logic [REG_W-1:0]  memwb_dst_q, memwb_dst_d;

  logic [CTRL_W-1:0] ctrl_clean;
  logic              stall;
  logic              idex_bubble;

  // rs travels with the instruction for downstream forwarding; not consumed here.
  logic unused_idex_rs;
  assign unused_idex_rs = ^idex_rs_q;

  // Don't-care bits arriving as X/Z resolve to 0 before capture.
  always_comb begin
    ctrl_clean = '0;
    for (int i = 0; i < int'(CTRL_W); i++) begin
      if (bus.inControl[i]) begin
        ctrl_clean[i] = 1'b1;
      end
    end
  end

  // Load-use hazard against the instruction in EX; a flush overrides it.
  always_comb begin
    stall = !bus.inFlush && bus.inValid && idex_ctrl_q[MemReadBit] &&
            (idex_rt_q != '0) && ((idex_rt_q == bus.inRs) || (idex_rt_q == bus.inRt));
    idex_bubble = bus.inFlush || stall || !bus.inValid;
  end

  // Next-state for all three stages.
  always_comb begin
    idex_ctrl_d = ctrl_clean;
    idex_rs_d   = bus.inRs;
    idex_rt_d   = bus.inRt;
    idex_rd_d   = bus.inRd;
    if (idex_bubble) begin
      idex_ctrl_d = '0;
      idex_rs_d   = '0;
      idex_rt_d   = '0;
      idex_rd_d   = '0;
    end

    exmem_ctrl_d = idex_ctrl_q[4:0];
    exmem_dst_d  = idex_ctrl_q[RegDstBit] ? idex_rd_q : idex_rt_q;
    if (bus.inFlush) begin
      exmem_ctrl_d = '0;
      exmem_dst_d  = '0;
    end

    // A write to $0 is never signalled.
    memwb_ctrl_d = exmem_ctrl_q[1:0];
    memwb_dst_d  = exmem_dst_q;
    if (exmem_dst_q == '0) begin
      memwb_ctrl_d[RegWriteBit] = 1'b0;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ctrl_q <= '0;
      idex_rs_q   <= '0;
      idex_rt_q   <= '0;
      idex_rd_q   <= '0;
    end else begin
      idex_ctrl_q <= idex_ctrl_d;
      idex_rs_q   <= idex_rs_d;
      idex_rt_q   <= idex_rt_d;
      idex_rd_q   <= idex_rd_d;
    end
  end

  // EX/MEM register.
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_ctrl_q <= '0;
      exmem_dst_q  <= '0;
    end else begin
      exmem_ctrl_q <= exmem_ctrl_d;
      exmem_dst_q  <= exmem_dst_d;
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      memwb_ctrl_q <= '0;
      memwb_dst_q  <= '0;
    end else begin
      memwb_ctrl_q <= memwb_ctrl_d;
      memwb_dst_q  <= memwb_dst_d;
    end
  end

  // Output fields; destination is only shown alongside an actual write.
  always_comb begin
    bus.outExCtrl   = idex_ctrl_q[8:5];
    bus.outMemCtrl  = exmem_ctrl_q[4:2];
    bus.outWbCtrl   = memwb_ctrl_q;
    bus.outWriteReg = memwb_ctrl_q[RegWriteBit] ? memwb_dst_q : '0;
    bus.outStall    = stall;
  end

endmodule
